// File: rtl/pwm_reg_pkg.sv
// Shared definitions for the PWM/output-enable register bank and its
// two-requester write arbiter.
package pwm_reg_pkg;

    localparam int NUM_REGS = 5;

    localparam int ADDR_OUT_7_0  = 0;
    localparam int ADDR_OUT_15_8 = 1;
    localparam int ADDR_PWM_7_0  = 2;
    localparam int ADDR_PWM_15_8 = 3;
    localparam int ADDR_DUTY     = 4;

    localparam logic [7:0] RST_REG  = 8'h00;
    localparam logic [7:0] RST_DUTY = 8'h00;

    typedef enum logic {
        GNT_SPI   = 1'b0,
        GNT_LOCAL = 1'b1
    } grant_e;

endpackage

// File: rtl/pwm_reg_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; remembers who was granted last and
// favours the other requester on a tie.
module rr_arb2
    import pwm_reg_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_spi,
    input  logic   req_loc,
    output logic   gnt_valid,
    output grant_e grant
);

    grant_e last_grant;

    always_comb begin
        gnt_valid = req_spi | req_loc;
        grant     = GNT_SPI;
        if (req_spi && req_loc)
            grant = (last_grant == GNT_SPI) ? GNT_LOCAL : GNT_SPI;
        else if (req_loc)
            grant = GNT_LOCAL;
    end

    // Starting at LOCAL hands the first tie to SPI.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= GNT_LOCAL;
        else if (gnt_valid)
            last_grant <= grant;
    end

endmodule

// File: rtl/pwm_reg_arbiter.sv
// PWM/output-enable register bank with a single write port shared between a
// non-stallable SPI decoder (via a 1-entry buffer) and a local valid/ready master.
module pwm_reg_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_wr_valid,
    input  logic [ADDR_W-1:0] spi_wr_addr,
    input  logic [DATA_W-1:0] spi_wr_data,
    input  logic              loc_wr_valid,
    output logic              loc_wr_ready,
    input  logic [ADDR_W-1:0] loc_wr_addr,
    input  logic [DATA_W-1:0] loc_wr_data,
    input  logic              period_end,
    output logic              spi_drop,
    output logic              err_addr,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle
);

    import pwm_reg_pkg::*;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] duty_shadow;
    logic              dup_pending;

    logic              gnt_valid;
    grant_e            grant;
    logic              spi_gnt;
    logic              loc_gnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_spi   (buf_valid),
        .req_loc   (loc_wr_valid),
        .gnt_valid (gnt_valid),
        .grant     (grant)
    );

    // Local handshake: a write transfers on a clock edge where loc_wr_valid and
    // loc_wr_ready are both high; ready depends only on registered state and
    // loc_wr_valid, and addr/data must be held stable until it is seen.
    always_comb begin
        spi_gnt = gnt_valid && (grant == GNT_SPI);
        loc_gnt = gnt_valid && (grant == GNT_LOCAL);
        wr_addr = spi_gnt ? buf_addr : loc_wr_addr;
        wr_data = spi_gnt ? buf_data : loc_wr_data;
    end

    assign loc_wr_ready = loc_gnt;

    // A full buffer can still accept a new pulse in the cycle it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            spi_drop  <= 1'b0;
        end else begin
            spi_drop <= 1'b0;
            if (spi_wr_valid && (!buf_valid || spi_gnt)) begin
                buf_valid <= 1'b1;
                buf_addr  <= spi_wr_addr;
                buf_data  <= spi_wr_data;
            end else if (spi_wr_valid) begin
                spi_drop <= 1'b1;
            end else if (spi_gnt) begin
                buf_valid <= 1'b0;
            end
        end
    end

    // The duty transfer is evaluated before the commit so a coincident
    // address-4 write re-arms dup_pending for the following period.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg_out_7_0  <= RST_REG;
            en_reg_out_15_8 <= RST_REG;
            en_reg_pwm_7_0  <= RST_REG;
            en_reg_pwm_15_8 <= RST_REG;
            pwm_duty_cycle  <= RST_DUTY;
            duty_shadow     <= RST_DUTY;
            dup_pending     <= 1'b0;
            err_addr        <= 1'b0;
        end else begin
            err_addr <= 1'b0;
            if (period_end && dup_pending) begin
                pwm_duty_cycle <= duty_shadow;
                dup_pending    <= 1'b0;
            end
            if (gnt_valid) begin
                if (wr_addr >= ADDR_W'(NUM_REGS)) begin
                    err_addr <= 1'b1;
                end else begin
                    case (wr_addr)
                        ADDR_W'(ADDR_OUT_7_0):  en_reg_out_7_0  <= wr_data;
                        ADDR_W'(ADDR_OUT_15_8): en_reg_out_15_8 <= wr_data;
                        ADDR_W'(ADDR_PWM_7_0):  en_reg_pwm_7_0  <= wr_data;
                        ADDR_W'(ADDR_PWM_15_8): en_reg_pwm_15_8 <= wr_data;
                        ADDR_W'(ADDR_DUTY): begin
                            duty_shadow <= wr_data;
                            dup_pending <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Self-checking bench for pwm_reg_arbiter: directed sequences plus a monitor
// that matches every visible register change against an expected queue.
module tb_pwm_reg_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int EXP_W  = 28;  // {due_cycle[15:0], reg_idx[3:0], value[7:0]}

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_wr_valid;
    logic [ADDR_W-1:0] spi_wr_addr;
    logic [DATA_W-1:0] spi_wr_data;
    logic              loc_wr_valid;
    logic              loc_wr_ready;
    logic [ADDR_W-1:0] loc_wr_addr;
    logic [DATA_W-1:0] loc_wr_data;
    logic              period_end;
    logic              spi_drop;
    logic              err_addr;
    logic [DATA_W-1:0] en_reg_out_7_0;
    logic [DATA_W-1:0] en_reg_out_15_8;
    logic [DATA_W-1:0] en_reg_pwm_7_0;
    logic [DATA_W-1:0] en_reg_pwm_15_8;
    logic [DATA_W-1:0] pwm_duty_cycle;

    pwm_reg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .spi_wr_valid    (spi_wr_valid),
        .spi_wr_addr     (spi_wr_addr),
        .spi_wr_data     (spi_wr_data),
        .loc_wr_valid    (loc_wr_valid),
        .loc_wr_ready    (loc_wr_ready),
        .loc_wr_addr     (loc_wr_addr),
        .loc_wr_data     (loc_wr_data),
        .period_end      (period_end),
        .spi_drop        (spi_drop),
        .err_addr        (err_addr),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] val, input int due);
        logic [15:0] d16;
        logic [3:0]  i4;
        d16 = 16'(due);
        i4  = 4'(idx);
        exp_q.push_back({d16, i4, val});
    endtask

    logic [DATA_W-1:0] prev [5];
    logic [DATA_W-1:0] cur  [5];
    logic [EXP_W-1:0]  mon_e;

    always @(negedge clk) begin
        cur[0] = en_reg_out_7_0;
        cur[1] = en_reg_out_15_8;
        cur[2] = en_reg_pwm_7_0;
        cur[3] = en_reg_pwm_15_8;
        cur[4] = pwm_duty_cycle;
        if (rst === 1'b0) begin
            for (int i = 0; i < 5; i++) begin
                if (cur[i] !== prev[i]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_change_reg%0d", i), 32'(cur[i]), 32'(prev[i]));
                    end else begin
                        mon_e = exp_q.pop_front();
                        check($sformatf("mon_idx_reg%0d", i), 32'(i), 32'(mon_e[11:8]));
                        check($sformatf("mon_val_reg%0d", i), 32'(cur[i]), 32'(mon_e[7:0]));
                        check($sformatf("mon_cycle_reg%0d", i), 32'(cyc), 32'(mon_e[27:12]));
                    end
                end
            end
        end
        for (int i = 0; i < 5; i++) prev[i] = cur[i];
    end

    // ---------------- driver tasks ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic spi(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        spi_wr_valid = 1'b1;
        spi_wr_addr  = a;
        spi_wr_data  = d;
    endtask

    task automatic loc(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        loc_wr_valid = 1'b1;
        loc_wr_addr  = a;
        loc_wr_data  = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_7_0"},  32'(en_reg_out_7_0),  32'h0);
        check({tag, "_out_15_8"}, 32'(en_reg_out_15_8), 32'h0);
        check({tag, "_pwm_7_0"},  32'(en_reg_pwm_7_0),  32'h0);
        check({tag, "_pwm_15_8"}, 32'(en_reg_pwm_15_8), 32'h0);
        check({tag, "_duty"},     32'(pwm_duty_cycle),  32'h0);
        check({tag, "_drop"},     32'(spi_drop),        32'h0);
        check({tag, "_err"},      32'(err_addr),        32'h0);
        check({tag, "_ready"},    32'(loc_wr_ready),    32'h0);
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] loc_d   [3] = '{8'h11, 8'h22, 8'h33};
    logic              exp_rdy [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic              exp_drp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int n;
        int k;
        rst = 1'b1; spi_wr_valid = 1'b0; spi_wr_addr = '0; spi_wr_data = '0;
        loc_wr_valid = 1'b0; loc_wr_addr = '0; loc_wr_data = '0; period_end = 1'b0;

        // Reset
        repeat (2) next();
        rst = 1'b0;
        sample();
        check_all_zero("reset");

        // SPI single write: visible exactly two cycles after the pulse
        next(); n = cyc; spi(7'd2, 8'hA5); push(2, 8'hA5, n + 2);
        next(); spi_wr_valid = 1'b0;
        sample(); check("spi_not_early", 32'(en_reg_pwm_7_0), 32'h0);
        next(); sample(); check("spi_single", 32'(en_reg_pwm_7_0), 32'hA5);
        next(); next();

        // Tie and round-robin (last_grant is SPI here)
        next(); n = cyc; k = 0;
        push(0, 8'h11, n + 1); push(1, 8'h81, n + 2); push(0, 8'h22, n + 3);
        push(1, 8'h82, n + 4); push(0, 8'h33, n + 5); push(1, 8'h84, n + 6);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next();
            spi_wr_valid = (i < 5);
            spi_wr_addr  = 7'd1;
            spi_wr_data  = 8'(8'h81 + i);
            loc_wr_valid = (k < 3);
            loc_wr_addr  = 7'd0;
            loc_wr_data  = (k < 3) ? loc_d[k] : 8'h00;
            sample();
            check($sformatf("rr_ready_%0d", i), 32'(loc_wr_ready), 32'(exp_rdy[i]));
            check($sformatf("rr_drop_%0d", i), 32'(spi_drop), 32'(exp_drp[i]));
            if (loc_wr_ready) k++;
        end
        next(); spi_wr_valid = 1'b0; loc_wr_valid = 1'b0;
        sample();
        check("rr_final_reg0", 32'(en_reg_out_7_0), 32'h33);
        check("rr_final_reg1", 32'(en_reg_out_15_8), 32'h84);

        // Overflow: second pulse arrives while local wins the tie
        next(); n = cyc; spi(7'd3, 8'hC1);
        sample(); check("ovf_ready_idle", 32'(loc_wr_ready), 32'h0);
        next(); spi(7'd3, 8'hC2); loc(7'd0, 8'h5A);
        push(0, 8'h5A, n + 2); push(3, 8'hC1, n + 3);
        sample(); check("ovf_loc_ready", 32'(loc_wr_ready), 32'h1);
        next(); spi_wr_valid = 1'b0; loc_wr_valid = 1'b0;
        sample(); check("ovf_drop_pulse", 32'(spi_drop), 32'h1);
        next(); sample();
        check("ovf_drop_end", 32'(spi_drop), 32'h0);
        check("ovf_first_kept", 32'(en_reg_pwm_15_8), 32'hC1);

        // Duty step 1: held until period_end
        next(); loc(7'd4, 8'h40);
        sample(); check("duty1_ready", 32'(loc_wr_ready), 32'h1);
        next(); loc_wr_valid = 1'b0;
        repeat (3) next();
        sample(); check("duty1_held", 32'(pwm_duty_cycle), 32'h0);
        next(); period_end = 1'b1; n = cyc; push(4, 8'h40, n + 1);
        next(); period_end = 1'b0;
        sample(); check("duty1_applied", 32'(pwm_duty_cycle), 32'h40);

        // Duty step 2: write coincident with period_end, nothing pending
        next(); loc(7'd4, 8'h80); period_end = 1'b1;
        sample(); check("duty2_ready", 32'(loc_wr_ready), 32'h1);
        next(); loc_wr_valid = 1'b0; period_end = 1'b0;
        sample(); check("duty2_hold", 32'(pwm_duty_cycle), 32'h40);
        next(); next(); period_end = 1'b1; n = cyc; push(4, 8'h80, n + 1);
        next(); period_end = 1'b0;
        sample(); check("duty2_applied", 32'(pwm_duty_cycle), 32'h80);

        // Duty step 3: coincident write while a value is pending
        next(); loc(7'd4, 8'h90);
        next(); loc(7'd4, 8'hA0); period_end = 1'b1; n = cyc; push(4, 8'h90, n + 1);
        sample(); check("duty3_ready", 32'(loc_wr_ready), 32'h1);
        next(); loc_wr_valid = 1'b0; period_end = 1'b0;
        sample(); check("duty3_old_shadow", 32'(pwm_duty_cycle), 32'h90);
        next(); period_end = 1'b1; n = cyc; push(4, 8'hA0, n + 1);
        next(); period_end = 1'b0;
        sample(); check("duty3_new_shadow", 32'(pwm_duty_cycle), 32'hA0);
        next(); period_end = 1'b1;
        next(); period_end = 1'b0;
        sample(); check("duty_no_pending", 32'(pwm_duty_cycle), 32'hA0);

        // Bad local address
        next(); loc(7'h7F, 8'hEE);
        sample();
        check("bad_loc_ready", 32'(loc_wr_ready), 32'h1);
        check("bad_loc_err_early", 32'(err_addr), 32'h0);
        next(); loc_wr_valid = 1'b0;
        sample(); check("bad_loc_err", 32'(err_addr), 32'h1);
        next(); sample(); check("bad_loc_err_end", 32'(err_addr), 32'h0);

        // Bad SPI address still frees the buffer for the next pulse
        next(); n = cyc; spi(7'd5, 8'h66);
        next(); spi(7'd0, 8'h77); push(0, 8'h77, n + 3);
        next(); spi_wr_valid = 1'b0;
        sample();
        check("bad_spi_err", 32'(err_addr), 32'h1);
        check("bad_spi_no_drop", 32'(spi_drop), 32'h0);
        next(); sample();
        check("bad_spi_next_write", 32'(en_reg_out_7_0), 32'h77);
        check("bad_spi_err_end", 32'(err_addr), 32'h0);

        // Reset mid-operation with a buffered SPI write and a pending duty value
        next(); loc(7'd4, 8'h55);
        next(); loc_wr_valid = 1'b0;
        next(); spi(7'd1, 8'h99);
        next(); spi_wr_valid = 1'b0; rst = 1'b1;
        check("queue_empty_before_reset", 32'(exp_q.size()), 32'h0);
        next(); next(); rst = 1'b0;
        sample(); check_all_zero("post_reset");
        next(); period_end = 1'b1;
        next(); period_end = 1'b0;
        repeat (3) next();
        sample(); check_all_zero("post_reset_idle");

        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
